// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MUL/MLA/UMULL/SMULL engine, WIDTH cycles per op.
// Define MULDIV_DIV_EN to compile in the UDIV/SDIV restoring-division datapath.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             FlushE,
  input  logic [2:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] SrcCE,
  output logic             BusyE,
  output logic             DoneE,
  output logic             StallE,
  output logic [WIDTH-1:0] ResultLoE,
  output logic [WIDTH-1:0] ResultHiE
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, stateNext;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, stepAcc, prod;
  logic [WIDTH-1:0]   opB, auxR, aMag, bMag, resLo, resHi;
  logic [WIDTH:0]     addSum;
  logic               isMla, isLong, negRes;
  logic               legalOp, takeStart, lastCycle, signedA, signedB;
`ifdef MULDIV_DIV_EN
  logic               isDiv, negRem, divZero, trialNeg;
  logic [WIDTH:0]     divShift, trial;
  logic [WIDTH-1:0]   quo, rem;
`endif

  always_comb begin
    legalOp = 1'b0;
    case (OpE)
      3'b000, 3'b001, 3'b100, 3'b101: legalOp = 1'b1;
`ifdef MULDIV_DIV_EN
      3'b110, 3'b111:                 legalOp = 1'b1;
`endif
      default:                        legalOp = 1'b0;
    endcase
  end

  assign takeStart = StartE & (state == IDLE) & legalOp & ~FlushE;
  assign lastCycle = (state == RUN) && (count == CW'(WIDTH - 1));
  assign signedA   = (OpE == 3'b101) || (OpE == 3'b111);
  assign signedB   = signedA;
  assign aMag      = (signedA & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign bMag      = (signedB & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (takeStart) stateNext = RUN;
      RUN:     if (lastCycle) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (FlushE) stateNext = IDLE;
  end

  assign BusyE  = (state == RUN);
  assign DoneE  = (state == DONE) & ~FlushE;
  assign StallE = BusyE | (StartE & (state == IDLE) & legalOp);

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  always_comb begin
    addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
    stepAcc = {addSum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = divShift - {1'b0, opB};
    trialNeg = trial[WIDTH];
    if (isDiv)
      stepAcc = {(trialNeg ? divShift[WIDTH-1:0] : trial[WIDTH-1:0]), acc[WIDTH-2:0], ~trialNeg};
`endif
    prod  = negRes ? -stepAcc : stepAcc;
    resLo = prod[WIDTH-1:0];
    resHi = prod[2*WIDTH-1:WIDTH];
    if (!isLong) begin
      resLo = prod[WIDTH-1:0] + (isMla ? auxR : {WIDTH{1'b0}});
      resHi = '0;
    end
`ifdef MULDIV_DIV_EN
    quo = negRes ? -stepAcc[WIDTH-1:0] : stepAcc[WIDTH-1:0];
    rem = negRem ? -stepAcc[2*WIDTH-1:WIDTH] : stepAcc[2*WIDTH-1:WIDTH];
    if (isDiv) begin
      resLo = divZero ? '0 : quo;
      resHi = divZero ? auxR : rem;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      opB       <= '0;
      auxR      <= '0;
      isMla     <= 1'b0;
      isLong    <= 1'b0;
      negRes    <= 1'b0;
      ResultLoE <= '0;
      ResultHiE <= '0;
`ifdef MULDIV_DIV_EN
      isDiv     <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
`endif
    end else if (takeStart) begin
      count  <= '0;
      isMla  <= (OpE == 3'b001);
      isLong <= OpE[2];
      negRes <= (OpE == 3'b101) & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
      opB    <= aMag;
      acc    <= {{WIDTH{1'b0}}, bMag};
      auxR   <= SrcCE;
`ifdef MULDIV_DIV_EN
      isDiv   <= (OpE[2:1] == 2'b11);
      negRem  <= 1'b0;
      divZero <= 1'b0;
      if (OpE[2:1] == 2'b11) begin
        opB     <= bMag;
        acc     <= {{WIDTH{1'b0}}, aMag};
        auxR    <= SrcAE;   // divide-by-zero returns the dividend unchanged
        negRes  <= OpE[0] & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
        negRem  <= OpE[0] & SrcAE[WIDTH-1];
        divZero <= (SrcBE == '0);
      end
`endif
    end else if (state == RUN) begin
      acc   <= stepAcc;
      count <= count + 1'b1;
      if (lastCycle && !FlushE) begin
        ResultLoE <= resLo;
        ResultHiE <= resHi;
      end
    end
  end
endmodule
